shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Multi-bit shift/rotate controller for the 8088 execution unit; sits directly upstream of the single-bit shifter.
- Accepts one shift-group operation (D0/D1 count=1, D2/D3 count=CL) and drives the shifter once per bit position, feeding each step's S and F_Carry back as the next step's A and carryIn.
- Presents the final result and flags to the EU write-back/flag logic with a done pulse.
- Count is not masked (8088 behaviour): up to 255 iterations.

Parameters:
- STEP_LAT, 3, cycles each step's operands are held before capture. Must be >=3: the shifter registers S, then derives flags from registered S.
- IDLE_ACK, 1, 1 = done pulses even for count 0; 0 = count 0 completes silently (busy only).

Ports:
- CLKx4  input  1  system clock, all state on rising edge
- RESET  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- A  input  16  operand; byte ops use [7:0]
- Operation  input  3  shift group encoding (000 ROL … 111 SAR, 110 aliases SHL)
- byteWord  input  1  1 = word, 0 = byte
- count  input  8  iteration count (1 or CL)
- carryIn  input  1  current CF
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle completion pulse
- result  output  16  final value, upper byte 0 for byte ops
- flagsOut  output  6  {O,S,Z,A,P,C} from the last step
- flagsValid  output  1  1 = flagsOut must be written to PSW (count != 0)
- shA  output  16  to shifter A
- shOperation  output  3  to shifter Operation
- shByteWord  output  1  to shifter byteWord
- shCarryIn  output  1  to shifter carryIn
- shS  input  16  from shifter S
- shFlags  input  6  from shifter {F_Overflow,F_Neg,F_Zero,F_Aux,F_Parity,F_Carry}

Behaviour:
- Reset: state IDLE. busy, done, flagsValid = 0; result, flagsOut, shA, shCarryIn = 0; shOperation = 000; shByteWord = 0.
- IDLE:
  - On start, latch Operation, byteWord, count into internal registers.
  - Load the working value with A, masked to [7:0] when byteWord = 0.
  - Load working carry with carryIn.
  - count = 0 -> DONE0. Otherwise -> STEP with remaining = count and phase counter = 0.
- STEP:
  - shA = working value, shCarryIn = working carry, shOperation/shByteWord = latched values; all held constant for STEP_LAT cycles.
  - On the last cycle's edge, capture shS into the working value and shFlags into the flag register; working carry <= shFlags[0].
  - Decrement remaining. Stay in STEP if remaining != 0, else -> DONE.
- DONE:
  - done = 1 for one cycle; result = working value; flagsOut = captured flags; flagsValid = 1; busy = 0 from this cycle.
  - -> IDLE.
- DONE0:
  - result = latched A; flagsValid = 0; flagsOut holds the previous value.
  - done = IDLE_ACK for one cycle.
  - -> IDLE.
- Latency for count N>=1: start in cycle t, done in cycle t+1+N*STEP_LAT. For count 0: done in cycle t+1.
- start while busy, or in DONE/DONE0, is ignored; no queueing.
- result, flagsOut and flagsValid hold their values until the next completion.
- Overflow is reported exactly as the shifter computes it on the final step, including count > 1.
- RESET mid-operation: next cycle is IDLE, no done pulse, outputs at reset values; a start in the same cycle as RESET is ignored.
- Byte ops: the shifter returns upper byte 0, so the working value stays byte-clean across steps.

Decomposition:
- Shared package eu_pkg:
  - Operation encodings: SH_ROL=3'b000 … SH_SAR=3'b111.
  - Flag bit indices: FLG_O=5 … FLG_C=0.
  - State enum {IDLE, STEP, DONE, DONE0}.
- Only sub-module: step_timer, a STEP_LAT-modulo phase counter with a last-phase strobe.
- The shifter is instantiated by the parent, not inside this block.

Test Plan:
- Byte SHL, A=0x0081, count=1, CF=0 -> done at t+4; result=0x0002; C=1; O=1; Z=0; flagsValid=1.
- Word RCR, A=0x0001, count=1, CF=1 -> result=0x8000; C=1; S=1.
- Byte ROL, A=0x0080, count=9 -> result=0x0001; C=1; done at t+28; busy high cycles t+1..t+27.
- Word SHR, A=0x1234, count=0 -> done at t+1; result=0x1234; flagsValid=0; flagsOut unchanged; no shifter operand change.
- Word SAR, A=0x8000, count=20 -> result=0xFFFF; C=1; S=1; Z=0; second start issued mid-run is ignored.
- Word SHL, count=200; RESET asserted at t+50 -> busy=0 and outputs reset at t+51; no done pulse; a new start at t+52 with count=1 completes normally.

Source files
------------

// File: rtl/eu_pkg.sv
// Shared execution-unit definitions: shift-group encodings, PSW flag bit
// positions and the shift sequencer state encoding.
package eu_pkg;

    localparam logic [2:0] SH_ROL = 3'b000;
    localparam logic [2:0] SH_ROR = 3'b001;
    localparam logic [2:0] SH_RCL = 3'b010;
    localparam logic [2:0] SH_RCR = 3'b011;
    localparam logic [2:0] SH_SHL = 3'b100;
    localparam logic [2:0] SH_SHR = 3'b101;
    localparam logic [2:0] SH_SAL = 3'b110;  // alias of SHL
    localparam logic [2:0] SH_SAR = 3'b111;

    localparam int FLG_O = 5;
    localparam int FLG_S = 4;
    localparam int FLG_Z = 3;
    localparam int FLG_A = 2;
    localparam int FLG_P = 1;
    localparam int FLG_C = 0;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE,
        DONE0
    } seq_state_e;

    // Byte operands live in [7:0] with a clean upper byte.
    function automatic logic [15:0] size_mask(input logic [15:0] value, input logic word);
        return {word ? value[15:8] : 8'h00, value[7:0]};
    endfunction

endpackage

// File: rtl/step_timer.sv
// Modulo-STEP_LAT phase counter; `last` marks the final cycle of each
// shifter step, on whose edge the sequencer captures the shifter outputs.
module step_timer #(
    parameter int unsigned STEP_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);

    localparam int unsigned W = (STEP_LAT > 1) ? $clog2(STEP_LAT) : 1;

    logic [W-1:0] phase_q, phase_d;

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        phase_d = phase_q;
        last    = 1'b0;
        if (clear) begin
            phase_d = '0;
        end else if (en) begin
            if (phase_q == W'(STEP_LAT - 1)) begin
                phase_d = '0;
                last    = 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift/rotate controller: iterates the single-bit shifter `count`
// times, feeding each step's result and carry back as the next step's input.
module shift_sequencer
    import eu_pkg::*;
#(
    parameter int unsigned STEP_LAT = 3,
    parameter bit          IDLE_ACK = 1'b1
) (
    input  logic        CLKx4,
    input  logic        RESET,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [2:0]  Operation,
    input  logic        byteWord,
    input  logic [7:0]  count,
    input  logic        carryIn,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [5:0]  flagsOut,
    output logic        flagsValid,
    output logic [15:0] shA,
    output logic [2:0]  shOperation,
    output logic        shByteWord,
    output logic        shCarryIn,
    input  logic [15:0] shS,
    input  logic [5:0]  shFlags
);

    seq_state_e  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        bw_q, bw_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [15:0] work_q, work_d;
    logic        carry_q, carry_d;
    logic [15:0] result_q, result_d;
    logic [5:0]  flags_out_q, flags_out_d;
    logic        flags_valid_q, flags_valid_d;

    logic timer_clear;
    logic timer_en;
    logic step_last;

    step_timer #(
        .STEP_LAT(STEP_LAT)
    ) u_step_timer (
        .clk  (CLKx4),
        .rst  (RESET),
        .clear(timer_clear),
        .en   (timer_en),
        .last (step_last)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        bw_d          = bw_q;
        remaining_d   = remaining_q;
        work_d        = work_q;
        carry_d       = carry_q;
        result_d      = result_q;
        flags_out_d   = flags_out_q;
        flags_valid_d = flags_valid_q;
        timer_clear   = 1'b0;
        timer_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // A zero count never touches the shifter operands.
                    if (count == 8'd0) begin
                        result_d      = size_mask(A, byteWord);
                        flags_valid_d = 1'b0;
                        state_d       = DONE0;
                    end else begin
                        op_d        = Operation;
                        bw_d        = byteWord;
                        remaining_d = count;
                        work_d      = size_mask(A, byteWord);
                        carry_d     = carryIn;
                        timer_clear = 1'b1;
                        state_d     = STEP;
                    end
                end
            end
            STEP: begin
                timer_en = 1'b1;
                if (step_last) begin
                    work_d      = shS;
                    carry_d     = shFlags[FLG_C];
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        result_d      = shS;
                        flags_out_d   = shFlags;
                        flags_valid_d = 1'b1;
                        state_d       = DONE;
                    end
                end
            end
            DONE, DONE0: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLKx4) begin
        if (RESET) begin
            state_q       <= IDLE;
            op_q          <= 3'b000;
            bw_q          <= 1'b0;
            remaining_q   <= 8'd0;
            work_q        <= 16'h0000;
            carry_q       <= 1'b0;
            result_q      <= 16'h0000;
            flags_out_q   <= 6'b000000;
            flags_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            bw_q          <= bw_d;
            remaining_q   <= remaining_d;
            work_q        <= work_d;
            carry_q       <= carry_d;
            result_q      <= result_d;
            flags_out_q   <= flags_out_d;
            flags_valid_q <= flags_valid_d;
        end
    end

    assign busy        = (state_q == STEP);
    assign done        = (state_q == DONE) || ((state_q == DONE0) && IDLE_ACK);
    assign result      = result_q;
    assign flagsOut    = flags_out_q;
    assign flagsValid  = flags_valid_q;
    assign shA         = work_q;
    assign shOperation = op_q;
    assign shByteWord  = bw_q;
    assign shCarryIn   = carry_q;

endmodule
